mlp_layer_sequencer: RTL and testbench
======================================

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning data/weight/bias width (two's complement).
REQ-002 SHALL have parameter FRAC, default 4, meaning fractional bits of fixed-point format.
REQ-003 SHALL have parameter NUM_INPUTS, default 62, meaning input vector length I.
REQ-004 SHALL have parameter NUM_HIDDEN, default 30, meaning hidden neuron count H.
REQ-005 SHALL have parameter NUM_OUTPUTS, default 10, meaning output neuron count O (>=2).
REQ-006 SHALL have parameter NUM_PU, default 8, meaning parallel MAC lanes P.
REQ-007 SHALL have parameter AW, default 10, meaning weight-memory address width.
REQ-008 SHALL have ports, in order: clk  in  1  clock; rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have ports: start  in  1  run request; data  in  I*N  input vector, element k at bits [k*N +: N].
REQ-010 SHALL have ports: w_rd_en  out  1  memory read strobe; w_addr  out  AW  read address; w_data  in  P*N  lane p at [p*N +: N], valid the cycle after w_rd_en.
REQ-011 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle completion pulse; label  out  clog2(O)  winning output index.

Function
REQ-012 SHALL capture data into an internal register on the cycle start is accepted (start=1 in IDLE); start while busy SHALL be ignored.
REQ-013 SHALL implement states IDLE -> HID -> OUT -> ARGMAX -> DONE -> IDLE; busy=1 in all states except IDLE.
REQ-014 SHALL process neurons in groups of P: G1=ceil(H/P) hidden groups, then G2=ceil(O/P) output groups; group g lane p computes neuron g*P+p.
REQ-015 SHALL, per group with K inputs (K=I hidden, K=H output), issue K+1 consecutive reads: offset 0 = bias per lane, offsets 1..K = weight for input k-1 per lane.
REQ-016 SHALL use base addresses: hidden group g = g*(I+1); output group g = G1*(I+1) + g*(H+1).
REQ-017 SHALL spend exactly K+3 cycles per group: K+1 read cycles, one final-accumulate cycle, one write-back cycle.
REQ-018 SHALL load the accumulator with bias<<FRAC, then add each N x N signed product; accumulator width 2N+clog2(K+1)+1, no internal overflow.
REQ-019 SHALL form each neuron result as accumulator arithmetic-shifted right by FRAC, reduced to N bits per REQ-029.
REQ-020 SHALL apply ReLU (negative -> 0) to hidden results only; output results are stored signed.
REQ-021 SHALL store hidden results in H registers used as the output-layer input vector; lanes with index >= H (or >= O) SHALL not be written.
REQ-022 SHALL, in ARGMAX, scan stored outputs index 0..O-1, one per cycle (O cycles), keeping the strictly greater value; ties resolve to the lowest index.
REQ-023 SHALL pulse done for exactly one cycle in DONE, and update label in the same cycle; label holds until the next done.
REQ-024 SHALL assert done exactly LAT = G1*(I+3) + G2*(H+3) + O + 1 cycles after the start-accepting edge.
REQ-025 SHALL drive w_rd_en=0 and w_addr=0 outside read cycles.

Reset
REQ-026 SHALL, on rst low, asynchronously force state IDLE, busy=0, done=0, label=0, w_rd_en=0, w_addr=0, clear accumulators, hidden and output result registers.
REQ-027 SHALL abort any run on mid-operation reset with no done pulse; the next accepted start SHALL run the full LAT.
REQ-028 SHALL, after rst deassertion, accept start on the first rising edge.

Configuration
REQ-029 SHALL, with macro MLP_LAYER_SATURATE_EN defined, saturate results to [-2^(N-1), 2^(N-1)-1]; without it, SHALL keep the low N bits (wrap).

Verification (N=8, FRAC=4, I=4, H=3, O=3, P=2 -> LAT=30)
REQ-030 SHALL cover: rst low mid-run at cycle 10 -> busy=0, label=0, no done; restart -> done exactly 30 cycles after start.
REQ-031 SHALL cover: all weights 0, output biases {5,9,2} -> label=1, done at cycle 30, one-cycle pulse.
REQ-032 SHALL cover: all weights 0, output biases {7,7,7} -> label=0 (tie rule).
REQ-033 SHALL cover: inputs 0x7F, hidden weights 0x7F -> hidden results 0x7F with MLP_LAYER_SATURATE_EN, wrapped low bytes without.
REQ-034 SHALL cover: hidden bias 0x80, weights 0 -> hidden result 0 (ReLU); start pulsed at cycle 5 while busy -> ignored, single done.
REQ-035 SHALL cover: w_addr sequence 0..4, 5..9, 10..13, 14..17 across groups, each read followed by data the next cycle.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
//   Two-layer MLP inference sequencer (hidden ReLU layer, linear output
//   layer, argmax). Neurons are evaluated NUM_PU at a time. Each lane fetches
//   its bias and weights from an external memory with one cycle of read
//   latency.
//
//   Ports
//     clk      clock
//     rst      asynchronous, active-low reset
//     start    run request, accepted only in IDLE
//     data     input vector, element k at [k*N +: N]
//     w_rd_en  weight-memory read strobe
//     w_addr   weight-memory read address (0 when not reading)
//     w_data   weight-memory lanes, lane p at [p*N +: N], valid one cycle after w_rd_en
//     busy     run in progress
//     done     one-cycle completion pulse
//     label    index of the largest output, held until the next done
//
//   Build option: define MLP_LAYER_SATURATE_EN to saturate neuron results to
//   N bits. When it is not defined, neuron results wrap to their low N bits.
module mlp_layer_sequencer #(
  parameter int N           = 8,
  parameter int FRAC        = 4,
  parameter int NUM_INPUTS  = 62,
  parameter int NUM_HIDDEN  = 30,
  parameter int NUM_OUTPUTS = 10,
  parameter int NUM_PU      = 8,
  parameter int AW          = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_INPUTS*N-1:0]           data,
  output logic                              w_rd_en,
  output logic [AW-1:0]                     w_addr,
  input  logic [NUM_PU*N-1:0]               w_data,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_OUTPUTS)-1:0]    label
);

  localparam int G1       = (NUM_HIDDEN + NUM_PU - 1) / NUM_PU;
  localparam int G2       = (NUM_OUTPUTS + NUM_PU - 1) / NUM_PU;
  localparam int GMAX     = (G1 > G2) ? G1 : G2;
  localparam int MAXK     = (NUM_INPUTS > NUM_HIDDEN) ? NUM_INPUTS : NUM_HIDDEN;
  localparam int ACC_W    = 2*N + $clog2(MAXK + 1) + 1;
  localparam int CW       = $clog2(MAXK + 3);
  localparam int GW       = $clog2(GMAX + 1);
  localparam int LW       = $clog2(NUM_OUTPUTS);
  localparam int OUT_BASE = G1 * (NUM_INPUTS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HID,
    ST_OUT,
    ST_ARGMAX,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [NUM_INPUTS*N-1:0] data_q, data_d;
  logic signed [ACC_W-1:0] acc_q [NUM_PU];
  logic signed [ACC_W-1:0] acc_d [NUM_PU];
  logic [N-1:0]            hid_q [NUM_HIDDEN];
  logic [N-1:0]            hid_d [NUM_HIDDEN];
  logic [N-1:0]            out_q [NUM_OUTPUTS];
  logic [N-1:0]            out_d [NUM_OUTPUTS];
  logic [LW-1:0]           scan_q, scan_d;
  logic [LW-1:0]           best_idx_q, best_idx_d;
  logic signed [N-1:0]     best_val_q, best_val_d;
  logic [LW-1:0]           label_q, label_d;

  logic [CW-1:0]           k_lim;
  logic                    grp_end;
  logic                    last_grp;
  logic signed [N-1:0]     op;
  logic signed [N-1:0]     lane;
  logic signed [2*N-1:0]   prod;

  function automatic logic [N-1:0] reduce_res(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
`ifdef MLP_LAYER_SATURATE_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = ACC_W'((2**(N-1)) - 1);
    sat_min = ~sat_max;
    s = a >>> FRAC;
    if (s > sat_max) s = sat_max;
    else if (s < sat_min) s = sat_min;
`else
    s = a >>> FRAC;
`endif
    return N'(s);
  endfunction

  function automatic logic [N-1:0] relu(input logic [N-1:0] v);
    return v[N-1] ? '0 : v;
  endfunction

  // Group bookkeeping: cycles 0..K issue reads, K+1 takes the last product,
  // K+2 writes the lanes back.
  always_comb begin
    k_lim    = (state_q == ST_OUT) ? CW'(NUM_HIDDEN) : CW'(NUM_INPUTS);
    grp_end  = ((state_q == ST_HID) || (state_q == ST_OUT)) && (cnt_q == k_lim + CW'(2));
    last_grp = (state_q == ST_OUT) ? (grp_q == GW'(G2 - 1)) : (grp_q == GW'(G1 - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_HID;
      ST_HID:    if (grp_end && last_grp) state_d = ST_OUT;
      ST_OUT:    if (grp_end && last_grp) state_d = ST_ARGMAX;
      ST_ARGMAX: if (scan_q == LW'(NUM_OUTPUTS - 1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    w_rd_en = 1'b0;
    w_addr  = '0;
    if (((state_q == ST_HID) || (state_q == ST_OUT)) && (cnt_q <= k_lim)) begin
      w_rd_en = 1'b1;
      if (state_q == ST_HID)
        w_addr = AW'(grp_q) * AW'(NUM_INPUTS + 1) + AW'(cnt_q);
      else
        w_addr = AW'(OUT_BASE) + AW'(grp_q) * AW'(NUM_HIDDEN + 1) + AW'(cnt_q);
    end
  end

  assign label = label_q;

  // Datapath
  always_comb begin
    cnt_d      = cnt_q;
    grp_d      = grp_q;
    data_d     = data_q;
    acc_d      = acc_q;
    hid_d      = hid_q;
    out_d      = out_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    label_d    = label_q;
    op         = '0;
    lane       = '0;
    prod       = '0;

    // Weight read at offset c pairs with input c-1 and arrives at cycle c+1.
    if (state_q == ST_OUT) begin
      for (int unsigned k = 0; k < NUM_HIDDEN; k++)
        if (cnt_q == CW'(k + 2)) op = hid_q[k];
    end else begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++)
        if (cnt_q == CW'(k + 2)) op = data_q[k*N +: N];
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        grp_d  = '0;
        scan_d = '0;
        if (start) data_d = data;
      end
      ST_HID, ST_OUT: begin
        cnt_d = grp_end ? '0 : cnt_q + CW'(1);
        if (grp_end) grp_d = last_grp ? '0 : grp_q + GW'(1);
        for (int unsigned p = 0; p < NUM_PU; p++) begin
          lane = w_data[p*N +: N];
          prod = lane * op;
          if (cnt_q == CW'(1))
            acc_d[p] = {{(ACC_W-N){lane[N-1]}}, lane} << FRAC;
          else if ((cnt_q >= CW'(2)) && (cnt_q <= k_lim + CW'(1)))
            acc_d[p] = acc_q[p] + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        end
        if (grp_end) begin
          if (state_q == ST_HID) begin
            for (int unsigned h = 0; h < NUM_HIDDEN; h++)
              if (grp_q == GW'(h / NUM_PU)) hid_d[h] = relu(reduce_res(acc_q[h % NUM_PU]));
          end else begin
            for (int unsigned o = 0; o < NUM_OUTPUTS; o++)
              if (grp_q == GW'(o / NUM_PU)) out_d[o] = reduce_res(acc_q[o % NUM_PU]);
          end
        end
      end
      ST_ARGMAX: begin
        scan_d = scan_q + LW'(1);
        if ((scan_q == '0) || ($signed(out_q[scan_q]) > best_val_q)) begin
          best_val_d = out_q[scan_q];
          best_idx_d = scan_q;
        end
        if (scan_q == LW'(NUM_OUTPUTS - 1)) label_d = best_idx_d;
      end
      default: scan_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      grp_q      <= '0;
      data_q     <= '0;
      acc_q      <= '{default: '0};
      hid_q      <= '{default: '0};
      out_q      <= '{default: '0};
      scan_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      label_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      grp_q      <= grp_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      hid_q      <= hid_d;
      out_q      <= out_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      label_q    <= label_d;
    end
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer with N=8, FRAC=4, I=4, H=3, O=3,
// P=2 (LAT=30). A behavioural memory answers reads one cycle late. Memory
// layout: addresses 0..4 and 5..9 hold the hidden groups, 10..13 and 14..17
// hold the output groups. Cycle 1 is the cycle that follows the edge
// accepting start, so done is expected high in cycle 30.
module tb_mlp_layer_sequencer;
  localparam int N = 8, FRAC = 4, I = 4, H = 3, O = 3, P = 2, AW = 10;
  localparam int LAT = 30, NADDR = 18;

`ifdef MLP_LAYER_SATURATE_EN
  localparam logic [7:0] BIG_HID = 8'h7F;
`else
  localparam logic [7:0] BIG_HID = 8'h10;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [I*N-1:0] data = '0;
  logic           w_rd_en;
  logic [AW-1:0]  w_addr;
  logic [P*N-1:0] w_data;
  logic           busy;
  logic           done;
  logic [1:0]     label;

  int checks = 0;
  int errors = 0;

  logic [7:0]     hb [4];
  logic [7:0]     hw [4];
  logic [7:0]     ob [4];
  logic [7:0]     ow [4];
  logic [P*N-1:0] mem [32];
  logic [AW-1:0]  addr_log [512];
  logic [8:0]     log_n = '0;
  int             done_total = 0;
  int             idle_addr_bad = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(
    .N(N), .FRAC(FRAC), .NUM_INPUTS(I), .NUM_HIDDEN(H),
    .NUM_OUTPUTS(O), .NUM_PU(P), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .label(label)
  );

  // Memory with one cycle of read latency; filler pattern between reads.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_data <= (w_addr < AW'(NADDR)) ? mem[w_addr[4:0]] : 16'hDEAD;
      addr_log[log_n] <= w_addr;
      log_n <= log_n + 9'd1;
    end else begin
      w_data <= 16'hA5A5;
    end
  end

  always @(negedge clk) begin
    if (done) done_total <= done_total + 1;
    if (!w_rd_en && (w_addr != '0)) idle_addr_bad <= idle_addr_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_params(input logic [7:0] hb0, hb1, hb2, hw0, hw1, hw2,
                            input logic [7:0] ob0, ob1, ob2, ow0, ow1, ow2);
    hb[0] = hb0; hb[1] = hb1; hb[2] = hb2; hb[3] = 8'h7F;
    hw[0] = hw0; hw[1] = hw1; hw[2] = hw2; hw[3] = 8'h7F;
    ob[0] = ob0; ob[1] = ob1; ob[2] = ob2; ob[3] = 8'h7F;
    ow[0] = ow0; ow[1] = ow1; ow[2] = ow2; ow[3] = 8'h7F;
    for (int a = 0; a < 32; a++) mem[a] = 16'hBEEF;
    for (int g = 0; g < 2; g++)
      for (int c = 0; c <= I; c++)
        mem[g*(I+1)+c] = (c == 0) ? {hb[2*g+1], hb[2*g]} : {hw[2*g+1], hw[2*g]};
    for (int g = 0; g < 2; g++)
      for (int c = 0; c <= H; c++)
        mem[10+g*(H+1)+c] = (c == 0) ? {ob[2*g+1], ob[2*g]} : {ow[2*g+1], ow[2*g]};
  endtask

  task automatic run_check(input string tag, input logic [1:0] exp_label, input int restart_at);
    int cyc;
    int d0;
    d0 = done_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, cyc, LAT);
    check_eq({tag, "_label"}, label, exp_label);
    @(negedge clk);
    check_eq({tag, "_pulse"}, done, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
    repeat (40) @(negedge clk);
    check_eq({tag, "_done_count"}, done_total - d0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_label", label, 0);
    check_eq("rst_rd_en", w_rd_en, 0);
    check_eq("rst_addr", w_addr, 0);
    @(posedge clk); #2; rst = 1'b1;

    // Zero weights: outputs equal their biases. Also the read address trace.
    set_params(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd9, 8'd2, 8'd0, 8'd0, 8'd0);
    b0 = log_n;
    run_check("bias592", 2'd1, 0);
    check_eq("addr_count", log_n - b0, NADDR);
    for (int i = 0; i < NADDR; i++) check_eq($sformatf("addr_%0d", i), addr_log[b0 + 9'(i)], i);

    set_params(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0);
    run_check("tie777", 2'd0, 0);

    set_params(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0);
    run_check("bias123", 2'd2, 0);

    set_params(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFB, 8'hFD, 8'hF7, 8'd0, 8'd0, 8'd0);
    run_check("negbias", 2'd1, 0);

    // x={1.0,2.0,0,0}: hidden {48,0(ReLU of -32),28}, outputs {76,80,24}.
    data = {8'd0, 8'd0, 8'd32, 8'd16};
    set_params(8'd0, 8'd16, 8'd4, 8'd16, 8'hF0, 8'd8, 8'd0, 8'd80, 8'd100, 8'd16, 8'd0, 8'hF0);
    run_check("mac", 2'd1, 0);
    check_eq("mac_hid0", dut.hid_q[0], 48);
    check_eq("mac_hid1", dut.hid_q[1], 0);
    check_eq("mac_hid2", dut.hid_q[2], 28);

    // Abort at cycle 10, then restart on the first edge after release.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_label", label, 0);
    check_eq("abort_rd_en", w_rd_en, 0);
    check_eq("abort_hid0", dut.hid_q[0], 0);
    @(posedge clk); #2; rst = 1'b1;
    run_check("restart", 2'd1, 0);
    check_eq("restart_hid0", dut.hid_q[0], 48);

    // (80 + 4*127*127/16) = 4112 -> saturates to 0x7F or wraps to 0x10.
    data = {4{8'h7F}};
    set_params(8'h50, 8'h50, 8'h50, 8'h7F, 8'h7F, 8'h7F, 8'd5, 8'd9, 8'd2, 8'd0, 8'd0, 8'd0);
    run_check("big", 2'd1, 0);
    check_eq("big_hid0", dut.hid_q[0], BIG_HID);
    check_eq("big_hid1", dut.hid_q[1], BIG_HID);
    check_eq("big_hid2", dut.hid_q[2], BIG_HID);

    // Bias -8.0 with zero weights clamps to 0; extra start at cycle 5.
    set_params(8'h80, 8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 8'd5, 8'd9, 8'd2, 8'd0, 8'd0, 8'd0);
    run_check("relu", 2'd1, 5);
    check_eq("relu_hid0", dut.hid_q[0], 0);
    check_eq("relu_hid1", dut.hid_q[1], 0);
    check_eq("relu_hid2", dut.hid_q[2], 0);

    check_eq("idle_addr_zero", idle_addr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
